// File: rtl/pe_pkg.sv
// ------------------------------------------------------------------
// pe_pkg: shared widths, state encoding and saturation constant for
// the PE accumulate stage.                            Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pe_pkg;

    localparam int PROD_W = 48;
    localparam int ACC_W  = 56;
    localparam int CNT_W  = 16;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pe_accumulator_if.sv
// ------------------------------------------------------------------
// pe_accumulator_if: product stream in, dot-product result out.
//                                                     Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pe_accumulator_if #(
    parameter int PROD_W = pe_pkg::PROD_W,
    parameter int ACC_W  = pe_pkg::ACC_W,
    parameter int CNT_W  = pe_pkg::CNT_W
);
    logic [CNT_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic              busy;

    modport master (
        output cfg_len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  cfg_len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/pe_accumulator_sat_add.sv
// ------------------------------------------------------------------
// sat_add: combinational unsigned adder clamping to all ones on carry.
//                                                     Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_add #(
    parameter int ACC_W = pe_pkg::ACC_W
) (
    input  wire logic [ACC_W-1:0] a,
    input  wire logic [ACC_W-1:0] b,
    output logic      [ACC_W-1:0] sum,
    output logic                  ovf
);

    logic [ACC_W:0] full_w;

    assign full_w = {1'b0, a} + {1'b0, b};
    assign ovf    = full_w[ACC_W];
    assign sum    = ovf ? {ACC_W{1'b1}} : full_w[ACC_W-1:0];

endmodule

`default_nettype wire

// File: rtl/pe_accumulator.sv
// ------------------------------------------------------------------
// pe_accumulator: sums a configured number of multiplier products and
// holds the saturated result behind a valid/ready register. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pe_accumulator #(
    parameter int PROD_W = pe_pkg::PROD_W,
    parameter int ACC_W  = pe_pkg::ACC_W,
    parameter int CNT_W  = pe_pkg::CNT_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pe_accumulator_if.slave acc_if
);
    import pe_pkg::*;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   len_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               beat_d;
    logic [CNT_W-1:0]   len_eff_d;
    logic [CNT_W-1:0]   cnt_inc_d;
    logic [ACC_W-1:0]   sum_d;
    logic               add_ovf_d;

    assign beat_d    = acc_if.in_valid && in_ready_q;
    assign len_eff_d = (acc_if.cfg_len == '0) ? CNT_W'(1) : acc_if.cfg_len;
    assign cnt_inc_d = cnt_q + CNT_W'(1);

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (ACC_W'(acc_if.in_prod)),
        .sum (sum_d),
        .ovf (add_ovf_d)
    );

    // in_ready is registered so it stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (beat_d) begin
                        acc_q  <= ACC_W'(acc_if.in_prod);
                        cnt_q  <= CNT_W'(1);
                        len_q  <= len_eff_d;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len_eff_d == CNT_W'(1)) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_d) begin
                        acc_q <= sum_d;
                        ovf_q <= ovf_q | add_ovf_d;
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d == len_q) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_if.out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign acc_if.in_ready  = in_ready_q;
    assign acc_if.out_valid = out_valid_q;
    assign acc_if.out_acc   = acc_q;
    assign acc_if.out_ovf   = ovf_q;
    assign acc_if.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_accumulator.sv
// ------------------------------------------------------------------
// tb_pe_accumulator: vector table, corner sequences and random dot
// products against a sum-and-clamp reference model.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pe_accumulator;

    localparam logic [63:0] MAX56 = 64'h00FF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [47:0] pq[$];

    pe_accumulator_if #(.PROD_W(48), .ACC_W(56), .CNT_W(16)) bus ();
    pe_accumulator_if #(.PROD_W(48), .ACC_W(48), .CNT_W(16)) b48 ();

    pe_accumulator #(.PROD_W(48), .ACC_W(56), .CNT_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc_if (bus)
    );

    pe_accumulator #(.PROD_W(48), .ACC_W(48), .CNT_W(16)) dut48 (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc_if (b48)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      len;
        logic [15:0]      alt;
        logic             use_alt;
        logic [3:0]       n;
        logic [3:0]       gap;
        logic [3:0]       stall;
        logic [3:0][47:0] p;
        logic [55:0]      acc;
        logic             ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain sum of all terms; any total above the 56-bit maximum clamps and flags.
    function automatic void model(output logic [55:0] acc, output logic ovf);
        logic [63:0] s;
        s = '0;
        foreach (pq[k]) s += 64'(pq[k]);
        ovf = (s > MAX56);
        acc = ovf ? '1 : s[55:0];
    endfunction

    // Called and returns at a negedge; pushes every term in pq then drains the result.
    task automatic run_dot(input string nm, input logic [15:0] len, input logic [15:0] alt,
                           input logic use_alt, input int gap, input int stall,
                           input logic [55:0] exp_acc, input logic exp_ovf);
        int t;
        for (int i = 0; i < pq.size(); i++) begin
            bus.cfg_len  = (i == 0 || !use_alt) ? len : alt;
            bus.in_valid = 1'b1;
            bus.in_prod  = pq[i];
            if (i == pq.size() - 1) check({nm, "_early_valid"}, 64'(bus.out_valid), 64'd0);
            t = 0;
            while (!bus.in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) begin
                check({nm, "_in_ready_timeout"}, 64'(bus.in_ready), 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (i < pq.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.out_ready = 1'b0;
            end
        end
        check({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({nm, "_in_ready_hold"}, 64'(bus.in_ready), 64'd0);
        check({nm, "_busy"}, 64'(bus.busy), 64'd1);
        check({nm, "_acc"}, 64'(bus.out_acc), 64'(exp_acc));
        check({nm, "_ovf"}, 64'(bus.out_ovf), 64'(exp_ovf));
        for (int s = 0; s < stall; s++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 48'($urandom());
            @(negedge clk);
            check({nm, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
            check({nm, "_stall_ready"}, 64'(bus.in_ready), 64'd0);
            check({nm, "_stall_acc"}, 64'(bus.out_acc), 64'(exp_acc));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({nm, "_done_valid"}, 64'(bus.out_valid), 64'd0);
        check({nm, "_done_ready"}, 64'(bus.in_ready), 64'd1);
        check({nm, "_done_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] e_acc;
        logic        e_ovf;
        logic [15:0] ln;
        logic [47:0] v;

        total = 0;
        bad   = 0;
        bus.cfg_len = '0; bus.in_valid = 1'b0; bus.in_prod = '0; bus.out_ready = 1'b0;
        b48.cfg_len = '0; b48.in_valid = 1'b0; b48.in_prod = '0; b48.out_ready = 1'b0;

        tbl[0] = '{len:16'd1, alt:16'd0, use_alt:1'b0, n:4'd1, gap:4'd0, stall:4'd0,
                   p:{48'd0, 48'd0, 48'd0, 48'd12345}, acc:56'd12345, ovf:1'b0};
        tbl[1] = '{len:16'd4, alt:16'd0, use_alt:1'b0, n:4'd4, gap:4'd0, stall:4'd0,
                   p:{48'd100, 48'd20, 48'd10, 48'd6}, acc:56'd136, ovf:1'b0};
        tbl[2] = '{len:16'd3, alt:16'd0, use_alt:1'b0, n:4'd3, gap:4'd2, stall:4'd5,
                   p:{48'd0, 48'd3, 48'd2, 48'd1}, acc:56'd6, ovf:1'b0};
        tbl[3] = '{len:16'd0, alt:16'd0, use_alt:1'b0, n:4'd1, gap:4'd0, stall:4'd1,
                   p:{48'd0, 48'd0, 48'd0, 48'd7}, acc:56'd7, ovf:1'b0};
        tbl[4] = '{len:16'd2, alt:16'd9, use_alt:1'b1, n:4'd2, gap:4'd1, stall:4'd0,
                   p:{48'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF},
                   acc:56'h01_FFFF_FFFF_FFFE, ovf:1'b0};
        tbl[5] = '{len:16'd4, alt:16'd0, use_alt:1'b0, n:4'd4, gap:4'd0, stall:4'd2,
                   p:{4{48'hFFFF_FFFF_FFFF}}, acc:56'h03_FFFF_FFFF_FFFC, ovf:1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_acc", 64'(bus.out_acc), 64'd0);
        check("rst_ovf", 64'(bus.out_ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_in_ready_pre", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_post", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            pq.delete();
            for (int j = 0; j < int'(tbl[i].n); j++) pq.push_back(tbl[i].p[j]);
            run_dot($sformatf("vec%0d", i), tbl[i].len, tbl[i].alt, tbl[i].use_alt,
                    int'(tbl[i].gap), int'(tbl[i].stall), tbl[i].acc, tbl[i].ovf);
        end

        // 48-bit build: overflow, sticky saturation, then a clean restart.
        b48.cfg_len = 16'd2; b48.in_valid = 1'b1; b48.in_prod = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        b48.in_prod = 48'h2;
        @(negedge clk);
        b48.in_valid = 1'b0;
        check("ovf48_valid", 64'(b48.out_valid), 64'd1);
        check("ovf48_acc", 64'(b48.out_acc), 64'hFFFF_FFFF_FFFF);
        check("ovf48_flag", 64'(b48.out_ovf), 64'd1);
        b48.out_ready = 1'b1;
        @(negedge clk);
        b48.out_ready = 1'b0;
        b48.cfg_len = 16'd3; b48.in_valid = 1'b1; b48.in_prod = 48'hFFFF_FFFF_FFF0;
        @(negedge clk);
        b48.in_prod = 48'h20;
        @(negedge clk);
        b48.in_prod = 48'h0;
        @(negedge clk);
        b48.in_valid = 1'b0;
        check("sticky48_acc", 64'(b48.out_acc), 64'hFFFF_FFFF_FFFF);
        check("sticky48_flag", 64'(b48.out_ovf), 64'd1);
        b48.out_ready = 1'b1;
        @(negedge clk);
        b48.out_ready = 1'b0;
        b48.cfg_len = 16'd1; b48.in_valid = 1'b1; b48.in_prod = 48'd5;
        @(negedge clk);
        b48.in_valid = 1'b0;
        check("clean48_valid", 64'(b48.out_valid), 64'd1);
        check("clean48_acc", 64'(b48.out_acc), 64'd5);
        check("clean48_flag", 64'(b48.out_ovf), 64'd0);
        b48.out_ready = 1'b1;
        @(negedge clk);
        b48.out_ready = 1'b0;

        // Asynchronous reset in the middle of a four-term product.
        bus.cfg_len = 16'd4; bus.in_valid = 1'b1; bus.in_prod = 48'd50;
        @(negedge clk);
        bus.in_prod = 48'd60;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_acc", 64'(bus.out_acc), 64'd0);
        check("mid_rst_ovf", 64'(bus.out_ovf), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rel_valid", 64'(bus.out_valid), 64'd0);
        pq.delete();
        pq.push_back(48'd3);
        pq.push_back(48'd4);
        run_dot("post_rst", 16'd2, 16'd0, 1'b0, 0, 0, 56'd7, 1'b0);

        // Accumulator width boundary: 256 max terms fit, 257 saturate.
        for (int r = 256; r <= 257; r++) begin
            pq.delete();
            for (int j = 0; j < r; j++) pq.push_back(48'hFFFF_FFFF_FFFF);
            model(e_acc, e_ovf);
            run_dot($sformatf("edge%0d", r), 16'(r), 16'd0, 1'b0, 0, 1, e_acc, e_ovf);
        end

        for (int r = 0; r < 25; r++) begin
            ln = 16'($urandom_range(0, 8));
            pq.delete();
            for (int j = 0; j < ((ln == 16'd0) ? 1 : int'(ln)); j++) begin
                case ($urandom_range(0, 2))
                    0:       v = 48'({$urandom(), $urandom()});
                    1:       v = 48'($urandom_range(0, 1000));
                    default: v = 48'hFFFF_FFFF_FFFF;
                endcase
                pq.push_back(v);
            end
            model(e_acc, e_ovf);
            run_dot($sformatf("rnd%0d", r), ln, 16'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), e_acc, e_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
